// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: atan2(y,x) in Q9.7 degrees plus magnitude, one operation in flight.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales mag by ~1/K (one extra cycle of latency).
module cordic_vector #(
    parameter int W     = 16,
    parameter int ITERS = 14,
    parameter int GW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [15:0]  angle,
    output logic [W:0]          mag
);
    localparam int IW = W + GW + 1;
    // z may overshoot a half turn by the sum of all atan steps, so it carries two extra bits
    localparam int ZW = 18;
    localparam logic signed [ZW-1:0] HALF_TURN = 18'sd23040;

    typedef enum logic [2:0] {IDLE, PRE, ITER, POST, GAIN, DONE} state_t;

    state_t state, state_nx;
    logic [3:0] iter;

    logic signed [W-1:0]  x_raw, y_raw;
    logic signed [IW-1:0] x_ext, y_ext;
    logic signed [IW-1:0] x_acc, y_acc;
    logic signed [IW-1:0] x_shr, y_shr;
    logic signed [IW-1:0] x_next, y_next;
    logic signed [ZW-1:0] z_acc, z_next, atan_i;
    logic                 dir;
    logic                 force_zero, force_pi;

    function automatic logic signed [ZW-1:0] atan_rom(input logic [3:0] i);
        case (i)
            4'd0:    atan_rom = 18'sd5760;
            4'd1:    atan_rom = 18'sd3400;
            4'd2:    atan_rom = 18'sd1797;
            4'd3:    atan_rom = 18'sd912;
            4'd4:    atan_rom = 18'sd458;
            4'd5:    atan_rom = 18'sd229;
            4'd6:    atan_rom = 18'sd115;
            4'd7:    atan_rom = 18'sd57;
            4'd8:    atan_rom = 18'sd29;
            4'd9:    atan_rom = 18'sd14;
            4'd10:   atan_rom = 18'sd7;
            4'd11:   atan_rom = 18'sd4;
            4'd12:   atan_rom = 18'sd2;
            4'd13:   atan_rom = 18'sd1;
            default: atan_rom = 18'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] sat_angle(input logic signed [ZW-1:0] z);
        logic signed [ZW-1:0] zs;
        if (z > HALF_TURN)
            zs = HALF_TURN;
        else if (z < -HALF_TURN)
            zs = -HALF_TURN;
        else
            zs = z;
        sat_angle = zs[15:0];
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    // 1/K ~ 0.60725 approximated as 2^-1 + 2^-3 - 2^-6 - 2^-9 + 2^-13
    function automatic logic [W:0] gain_comp(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] g;
        g = (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) + (v >>> 13);
        gain_comp = g[W:0];
    endfunction
`endif

    assign x_ext = {{(GW+1){x_raw[W-1]}}, x_raw};
    assign y_ext = {{(GW+1){y_raw[W-1]}}, y_raw};

    assign dir    = ~y_acc[IW-1];
    assign y_shr  = y_acc >>> iter;
    assign x_shr  = x_acc >>> iter;
    assign atan_i = atan_rom(iter);
    assign x_next = dir ? (x_acc + y_shr) : (x_acc - y_shr);
    assign y_next = dir ? (y_acc - x_shr) : (y_acc + x_shr);
    assign z_next = dir ? (z_acc + atan_i) : (z_acc - atan_i);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = PRE;
            PRE:  state_nx = ITER;
            ITER: if (iter == 4'(ITERS - 1)) state_nx = POST;
`ifdef CORDIC_GAIN_COMP_EN
            POST: state_nx = GAIN;
`else
            POST: state_nx = DONE;
`endif
            GAIN: state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, pre-rotation into the right half-plane, micro-rotations
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            x_raw <= x_in;
            y_raw <= y_in;
        end
        case (state)
            PRE: begin
                if (x_raw < 0) begin
                    x_acc <= -x_ext;
                    y_acc <= -y_ext;
                    z_acc <= (y_raw >= 0) ? HALF_TURN : -HALF_TURN;
                end else begin
                    x_acc <= x_ext;
                    y_acc <= y_ext;
                    z_acc <= '0;
                end
                force_zero <= (x_raw == 0) && (y_raw == 0);
                force_pi   <= (y_raw == 0) && (x_raw < 0);
            end
            ITER: begin
                x_acc <= x_next;
                y_acc <= y_next;
                z_acc <= z_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            iter  <= '0;
            angle <= '0;
            mag   <= '0;
        end else begin
            state <= state_nx;
            iter  <= (state == ITER) ? iter + 4'd1 : 4'd0;
            if (state == POST) begin
                // The negative real axis and the origin would otherwise land a few LSB off
                if (force_zero)
                    angle <= '0;
                else if (force_pi)
                    angle <= 16'sd23040;
                else
                    angle <= sat_angle(z_acc);
`ifndef CORDIC_GAIN_COMP_EN
                mag <= x_acc[W:0];
`endif
            end
`ifdef CORDIC_GAIN_COMP_EN
            if (state == GAIN)
                mag <= gain_comp(x_acc);
`endif
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: angles/magnitudes on axes, diagonal, origin, stall and abort.
module tb_cordic_vector;
    localparam int W = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT      = 18;
    localparam int MAG_X    = 16384;
    localparam int MAG_X_T  = 12;
    localparam int MAG_D    = 14142;
    localparam int MAG_D_T  = 16;
    localparam int MAG_N    = 32768;
`else
    localparam int LAT      = 17;
    localparam int MAG_X    = 26981;
    localparam int MAG_X_T  = 2;
    localparam int MAG_D    = 23289;
    localparam int MAG_D_T  = 2;
    localparam int MAG_N    = 53962;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [15:0]  angle;
    logic [W:0]          mag;

    int n_checks = 0;
    int n_fail   = 0;

    cordic_vector dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle     (angle),
        .mag       (mag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
        n_checks++;
        if ((obs - exp > tol) || (exp - obs > tol)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Issue one operation; returns angle, mag and cycles from accept edge (counted as 1) to out_valid
    task automatic run_op(input int xv, input int yv, input bit release_out,
                          output int a, output int m, output int lat);
        int w;
        @(negedge clk);
        x_in     = W'(xv);
        y_in     = W'(yv);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("out_valid_seen", out_valid, 1);
        a = angle;
        m = mag;
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, m, lat;
        int a0, m0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_angle", angle, 0);
        check("rst_mag", mag, 0);
        rst = 1'b0;

        run_op(16384, 0, 1'b1, a, m, lat);
        check("pos_x_lat", lat, LAT);
        check("pos_x_angle", a, 0, 2);
        check("pos_x_mag", m, MAG_X, MAG_X_T);
        check("idle_after_ack", in_ready, 1);

        run_op(0, 16384, 1'b1, a, m, lat);
        check("pos_y_angle", a, 11520, 2);
        run_op(0, -16384, 1'b1, a, m, lat);
        check("neg_y_angle", a, -11520, 2);
        run_op(-16384, 0, 1'b1, a, m, lat);
        check("neg_x_angle", a, 23040);
        run_op(-32768, -1, 1'b1, a, m, lat);
        check("min_x_angle", a, -23040, 2);
        check("min_x_mag", m, MAG_N, 56);
        run_op(0, 0, 1'b1, a, m, lat);
        check("zero_angle", a, 0);
        check("zero_mag", m, 0);
        check("zero_lat", lat, LAT);

        // Result held under back-pressure; new requests are not accepted or queued
        run_op(10000, 10000, 1'b0, a0, m0, lat);
        check("diag_angle", a0, 5760, 2);
        check("diag_mag", m0, MAG_D, MAG_D_T);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_in = W'(-1234 * (k + 1));
            y_in = W'(777 * (k + 1));
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_angle", angle, a0);
            check("stall_mag", mag, m0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("ack_out_valid", out_valid, 0);
        check("ack_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("not_queued", in_ready, 1);

        // Abort during iteration 6
        @(negedge clk);
        x_in     = 16'sd16384;
        y_in     = 16'sd0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_angle", angle, 0);
        check("abort_mag", mag, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 16384, 1'b1, a, m, lat);
        check("post_abort_angle", a, 11520, 2);
        check("post_abort_lat", lat, LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
